// File: rtl/rf_operand_sequencer.sv
// Operand sequencer for an 8-entry register file: fetch, dispatch and writeback with a pending scoreboard.
// Optional macro RF_SEQ_BYPASS_EN forwards a same-cycle commit into the fetch stage.
module rf_operand_sequencer #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [ADDR_W-1:0]      req_src1,
    input  logic [ADDR_W-1:0]      req_src2,
    input  logic [ADDR_W-1:0]      req_dst,
    input  logic                   req_wb,
    output logic [ADDR_W-1:0]      rf_rd1_add,
    output logic [ADDR_W-1:0]      rf_rd2_add,
    input  logic [DATA_W-1:0]      rf_rd1_data,
    input  logic [DATA_W-1:0]      rf_rd2_data,
    output logic                   ex_valid,
    input  logic                   ex_ready,
    output logic [DATA_W-1:0]      ex_op1,
    output logic [DATA_W-1:0]      ex_op2,
    output logic [ADDR_W-1:0]      ex_dst,
    output logic                   ex_wb,
    input  logic                   wb_valid,
    input  logic [ADDR_W-1:0]      wb_dst,
    input  logic [DATA_W-1:0]      wb_data,
    output logic                   rf_wr_en,
    output logic [ADDR_W-1:0]      rf_wr_add,
    output logic [DATA_W-1:0]      rf_wr_data,
    output logic [2**ADDR_W-1:0]   pending
);
    localparam int NREG = 2**ADDR_W;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DISPATCH} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   src1_q;
    logic [ADDR_W-1:0]   src2_q;
    logic [ADDR_W-1:0]   dst_q;
    logic                wb_q;
    logic                hazard;
    logic                capture;
    logic [NREG-1:0]     pend_eff;
    logic [NREG-1:0]     pending_nxt;
    logic [DATA_W-1:0]   op1_sel;
    logic [DATA_W-1:0]   op2_sel;

    // The latched sources double as the read addresses, so they hold outside S_FETCH.
    assign rf_rd1_add = src1_q;
    assign rf_rd2_add = src2_q;

    always_comb begin
        pend_eff = pending;
`ifdef RF_SEQ_BYPASS_EN
        // A commit in flight this cycle resolves its register and supplies the data directly.
        if (rf_wr_en) pend_eff[rf_wr_add] = 1'b0;
        op1_sel = (rf_wr_en && (rf_wr_add == src1_q)) ? rf_wr_data : rf_rd1_data;
        op2_sel = (rf_wr_en && (rf_wr_add == src2_q)) ? rf_wr_data : rf_rd2_data;
`else
        op1_sel = rf_rd1_data;
        op2_sel = rf_rd2_data;
`endif
        hazard = pend_eff[src1_q] | pend_eff[src2_q] | (wb_q & pend_eff[dst_q]);
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        ex_valid  = 1'b0;
        capture   = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = S_FETCH;
            end
            S_FETCH: begin
                if (!hazard) begin
                    capture   = 1'b1;
                    state_nxt = S_DISPATCH;
                end
            end
            S_DISPATCH: begin
                ex_valid = 1'b1;
                if (ex_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            src1_q <= '0;
            src2_q <= '0;
            dst_q  <= '0;
            wb_q   <= 1'b0;
            ex_op1 <= '0;
            ex_op2 <= '0;
            ex_dst <= '0;
            ex_wb  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (req_valid && req_ready) begin
                src1_q <= req_src1;
                src2_q <= req_src2;
                dst_q  <= req_dst;
                wb_q   <= req_wb;
            end
            if (capture) begin
                ex_op1 <= op1_sel;
                ex_op2 <= op2_sel;
                ex_dst <= dst_q;
                ex_wb  <= wb_q;
            end
        end
    end

    // Set after clear: a new claim on the same edge as a commit must survive.
    always_comb begin
        pending_nxt = pending;
        if (rf_wr_en) pending_nxt[rf_wr_add] = 1'b0;
        if (capture && wb_q) pending_nxt[dst_q] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending    <= '0;
            rf_wr_en   <= 1'b0;
            rf_wr_add  <= '0;
            rf_wr_data <= '0;
        end else begin
            pending  <= pending_nxt;
            rf_wr_en <= wb_valid;
            if (wb_valid) begin
                rf_wr_add  <= wb_dst;
                rf_wr_data <= wb_data;
            end
        end
    end
endmodule

// File: tb/tb_rf_operand_sequencer.sv
// Bench for rf_operand_sequencer: register file model, operand scoreboard and per-scenario tasks.
module tb_rf_operand_sequencer;
    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid, req_ready, req_wb;
    logic [2:0] req_src1, req_src2, req_dst;
    logic [2:0] rf_rd1_add, rf_rd2_add;
    logic [7:0] rf_rd1_data, rf_rd2_data;
    logic       ex_valid, ex_ready, ex_wb;
    logic [7:0] ex_op1, ex_op2;
    logic [2:0] ex_dst;
    logic       wb_valid;
    logic [2:0] wb_dst;
    logic [7:0] wb_data;
    logic       rf_wr_en;
    logic [2:0] rf_wr_add;
    logic [7:0] rf_wr_data;
    logic [7:0] pending;

    typedef struct packed {
        logic [7:0] op1;
        logic [7:0] op2;
        logic [2:0] dst;
        logic       wb;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    logic [7:0] rf_mem [8] = '{default: 8'h00};

    always #5 clk = ~clk;

    rf_operand_sequencer #(.DATA_W(8), .ADDR_W(3)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_src1(req_src1), .req_src2(req_src2), .req_dst(req_dst), .req_wb(req_wb),
        .rf_rd1_add(rf_rd1_add), .rf_rd2_add(rf_rd2_add),
        .rf_rd1_data(rf_rd1_data), .rf_rd2_data(rf_rd2_data),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_dst(ex_dst), .ex_wb(ex_wb),
        .wb_valid(wb_valid), .wb_dst(wb_dst), .wb_data(wb_data),
        .rf_wr_en(rf_wr_en), .rf_wr_add(rf_wr_add), .rf_wr_data(rf_wr_data),
        .pending(pending)
    );

    // External register file: combinational read, write committed on the clock edge.
    assign rf_rd1_data = rf_mem[rf_rd1_add];
    assign rf_rd2_data = rf_mem[rf_rd2_add];
    always @(posedge clk) if (rf_wr_en) rf_mem[rf_wr_add] <= rf_wr_data;

    // Inputs change 1ns after the rising edge, so a handshake seen here is what the next edge takes.
    always @(negedge clk) begin
        if (reset && ex_valid && ex_ready) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected: got op1=%h op2=%h dst=%0d wb=%0b, no entry queued",
                         ex_op1, ex_op2, ex_dst, ex_wb);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if ({ex_op1, ex_op2, ex_dst, ex_wb} !== e) begin
                    n_err++;
                    $display("FAIL sb_operands: got op1=%h op2=%h dst=%0d wb=%0b want op1=%h op2=%h dst=%0d wb=%0b",
                             ex_op1, ex_op2, ex_dst, ex_wb, e.op1, e.op2, e.dst, e.wb);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_req(input logic [2:0] s1, input logic [2:0] s2, input logic [2:0] d, input logic w,
                            input logic [7:0] e1, input logic [7:0] e2);
        exp_t e;
        req_valid = 1'b1; req_src1 = s1; req_src2 = s2; req_dst = d; req_wb = w;
        e.op1 = e1; e.op2 = e2; e.dst = d; e.wb = w;
        sb_q.push_back(e);
        cyc();
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req_valid = 0; req_src1 = 0; req_src2 = 0; req_dst = 0; req_wb = 0;
        ex_ready = 0; wb_valid = 0; wb_dst = 0; wb_data = 0;
        #3;
        n_cmp++;
        if ({ex_valid, rf_wr_en, pending, rf_rd1_add, rf_rd2_add} !== 16'h0) begin
            n_err++;
            $display("FAIL reset_ctrl: got ex_valid=%0b wr_en=%0b pending=%h rd1=%0d rd2=%0d want all 0",
                     ex_valid, rf_wr_en, pending, rf_rd1_add, rf_rd2_add);
        end
        n_cmp++;
        if ({ex_op1, ex_op2, ex_dst, ex_wb, rf_wr_add, rf_wr_data} !== 31'h0) begin
            n_err++;
            $display("FAIL reset_data: got op1=%h op2=%h dst=%0d wb=%0b wr_add=%0d wr_data=%h want all 0",
                     ex_op1, ex_op2, ex_dst, ex_wb, rf_wr_add, rf_wr_data);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        cyc();
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_req_ready: got %0b want 1", req_ready);
        end
    endtask

    task automatic test_preload();
        wb_valid = 1; wb_dst = 2; wb_data = 8'h3C;
        cyc();
        n_cmp++;
        if ({rf_wr_en, rf_wr_add, rf_wr_data, pending} !== {1'b1, 3'd2, 8'h3C, 8'h00}) begin
            n_err++;
            $display("FAIL preload_r2: got en=%0b add=%0d data=%h pend=%h want 1 2 3c 00",
                     rf_wr_en, rf_wr_add, rf_wr_data, pending);
        end
        wb_dst = 5; wb_data = 8'hA1;
        cyc();
        n_cmp++;
        if ({rf_wr_en, rf_wr_add, rf_wr_data} !== {1'b1, 3'd5, 8'hA1}) begin
            n_err++;
            $display("FAIL preload_r5: got en=%0b add=%0d data=%h want 1 5 a1", rf_wr_en, rf_wr_add, rf_wr_data);
        end
        wb_valid = 0;
        cyc();
        n_cmp++;
        if (rf_wr_en !== 1'b0) begin
            n_err++;
            $display("FAIL preload_pulse_end: got en=%0b want 0", rf_wr_en);
        end
        send_req(3'd2, 3'd5, 3'd7, 1'b1, 8'h3C, 8'hA1);
        n_cmp++;
        if ({req_ready, ex_valid, rf_rd1_add, rf_rd2_add} !== {1'b0, 1'b0, 3'd2, 3'd5}) begin
            n_err++;
            $display("FAIL preload_fetch: got rdy=%0b exv=%0b rd1=%0d rd2=%0d want 0 0 2 5",
                     req_ready, ex_valid, rf_rd1_add, rf_rd2_add);
        end
        cyc();
        n_cmp++;
        if ({ex_valid, ex_op1, ex_op2, ex_dst, pending} !== {1'b1, 8'h3C, 8'hA1, 3'd7, 8'h80}) begin
            n_err++;
            $display("FAIL preload_dispatch: got exv=%0b op1=%h op2=%h dst=%0d pend=%h want 1 3c a1 7 80",
                     ex_valid, ex_op1, ex_op2, ex_dst, pending);
        end
        ex_ready = 1;
        cyc();
        ex_ready = 0;
        n_cmp++;
        if ({ex_valid, req_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL preload_done: got exv=%0b rdy=%0b want 0 1", ex_valid, req_ready);
        end
    endtask

    task automatic test_raw();
        send_req(3'd7, 3'd0, 3'd1, 1'b0, 8'h55, 8'h00);
        cyc();
        n_cmp++;
        if (ex_valid !== 1'b0) begin
            n_err++;
            $display("FAIL raw_stall: got exv=%0b want 0", ex_valid);
        end
        wb_valid = 1; wb_dst = 7; wb_data = 8'h55;
        cyc();
        wb_valid = 0;
        n_cmp++;
        if ({rf_wr_en, rf_wr_add, pending, ex_valid} !== {1'b1, 3'd7, 8'h80, 1'b0}) begin
            n_err++;
            $display("FAIL raw_commit: got en=%0b add=%0d pend=%h exv=%0b want 1 7 80 0",
                     rf_wr_en, rf_wr_add, pending, ex_valid);
        end
        cyc();
`ifdef RF_SEQ_BYPASS_EN
        n_cmp++;
        if ({pending, ex_valid} !== {8'h00, 1'b1}) begin
            n_err++;
            $display("FAIL raw_bypass: got pend=%h exv=%0b want 00 1", pending, ex_valid);
        end
`else
        n_cmp++;
        if ({pending, ex_valid} !== {8'h00, 1'b0}) begin
            n_err++;
            $display("FAIL raw_clear: got pend=%h exv=%0b want 00 0", pending, ex_valid);
        end
`endif
        cyc();
        n_cmp++;
        if ({ex_valid, ex_op1} !== {1'b1, 8'h55}) begin
            n_err++;
            $display("FAIL raw_dispatch: got exv=%0b op1=%h want 1 55", ex_valid, ex_op1);
        end
        ex_ready = 1;
        cyc();
        ex_ready = 0;
    endtask

    task automatic test_waw();
        wb_valid = 1; wb_dst = 0; wb_data = 8'h11;
        cyc();
        wb_dst = 1; wb_data = 8'h22;
        cyc();
        wb_valid = 0;
        cyc();
        send_req(3'd0, 3'd1, 3'd3, 1'b1, 8'h11, 8'h22);
        cyc();
        ex_ready = 1;
        cyc();
        ex_ready = 0;
        send_req(3'd0, 3'd1, 3'd3, 1'b1, 8'h11, 8'h22);
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_cmp++;
            if ({ex_valid, pending} !== {1'b0, 8'h08}) begin
                n_err++;
                $display("FAIL waw_stall[%0d]: got exv=%0b pend=%h want 0 08", i, ex_valid, pending);
            end
        end
        wb_valid = 1; wb_dst = 3; wb_data = 8'h77;
        cyc();
        wb_valid = 0;
        cyc();
`ifdef RF_SEQ_BYPASS_EN
        n_cmp++;
        if ({ex_valid, pending} !== {1'b1, 8'h08}) begin
            n_err++;
            $display("FAIL waw_bypass: got exv=%0b pend=%h want 1 08", ex_valid, pending);
        end
`else
        n_cmp++;
        if ({ex_valid, pending} !== {1'b0, 8'h00}) begin
            n_err++;
            $display("FAIL waw_clear: got exv=%0b pend=%h want 0 00", ex_valid, pending);
        end
`endif
        cyc();
        n_cmp++;
        if ({ex_valid, ex_dst, pending} !== {1'b1, 3'd3, 8'h08}) begin
            n_err++;
            $display("FAIL waw_reclaim: got exv=%0b dst=%0d pend=%h want 1 3 08", ex_valid, ex_dst, pending);
        end
        ex_ready = 1;
        cyc();
        ex_ready = 0;
        wb_valid = 1; wb_dst = 3; wb_data = 8'h77;
        cyc();
        wb_valid = 0;
        cyc();
    endtask

    task automatic test_backpressure();
        send_req(3'd3, 3'd2, 3'd6, 1'b0, 8'h77, 8'h3C);
        cyc();
        req_valid = 1; req_src1 = 3'd5; req_src2 = 3'd5; req_dst = 3'd5; req_wb = 1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if ({ex_valid, req_ready, ex_op1, ex_op2, ex_dst} !== {1'b1, 1'b0, 8'h77, 8'h3C, 3'd6}) begin
                n_err++;
                $display("FAIL bp_hold[%0d]: got exv=%0b rdy=%0b op1=%h op2=%h dst=%0d want 1 0 77 3c 6",
                         i, ex_valid, req_ready, ex_op1, ex_op2, ex_dst);
            end
            cyc();
        end
        req_valid = 0;
        ex_ready = 1;
        cyc();
        ex_ready = 0;
        n_cmp++;
        if ({ex_valid, req_ready, pending} !== {1'b0, 1'b1, 8'h00}) begin
            n_err++;
            $display("FAIL bp_release: got exv=%0b rdy=%0b pend=%h want 0 1 00", ex_valid, req_ready, pending);
        end
    endtask

    task automatic test_reset_mid();
        req_valid = 1; req_src1 = 0; req_src2 = 1; req_dst = 4; req_wb = 1;
        cyc();
        req_valid = 0;
        cyc();
        wb_valid = 1; wb_dst = 6; wb_data = 8'h66;
        cyc();
        wb_valid = 0;
        n_cmp++;
        if ({ex_valid, pending, rf_wr_en} !== {1'b1, 8'h10, 1'b1}) begin
            n_err++;
            $display("FAIL rstmid_setup: got exv=%0b pend=%h en=%0b want 1 10 1", ex_valid, pending, rf_wr_en);
        end
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if ({ex_valid, pending, rf_wr_en} !== {1'b0, 8'h00, 1'b0}) begin
            n_err++;
            $display("FAIL rstmid_async: got exv=%0b pend=%h en=%0b want 0 00 0", ex_valid, pending, rf_wr_en);
        end
        @(negedge clk);
        reset = 1'b1;
        cyc();
        n_cmp++;
        if ({req_ready, ex_valid} !== 2'b10) begin
            n_err++;
            $display("FAIL rstmid_release: got rdy=%0b exv=%0b want 1 0", req_ready, ex_valid);
        end
    endtask

    task automatic test_nonpending_wb();
        wb_valid = 1; wb_dst = 4; wb_data = 8'hFF;
        cyc();
        wb_valid = 0;
        n_cmp++;
        if ({rf_wr_en, rf_wr_add, rf_wr_data, pending} !== {1'b1, 3'd4, 8'hFF, 8'h00}) begin
            n_err++;
            $display("FAIL npwb_pulse: got en=%0b add=%0d data=%h pend=%h want 1 4 ff 00",
                     rf_wr_en, rf_wr_add, rf_wr_data, pending);
        end
        ex_ready = 1;
        send_req(3'd4, 3'd4, 3'd0, 1'b0, 8'hFF, 8'hFF);
        n_cmp++;
        if ({rf_wr_en, pending} !== {1'b0, 8'h00}) begin
            n_err++;
            $display("FAIL npwb_after: got en=%0b pend=%h want 0 00", rf_wr_en, pending);
        end
        begin
            int wait_cyc = 0;
            while (!ex_valid && wait_cyc < 10) begin
                cyc();
                wait_cyc++;
            end
            n_cmp++;
            if (wait_cyc != 1) begin
                n_err++;
                $display("FAIL npwb_latency: got %0d cycles to ex_valid want 1", wait_cyc);
            end
        end
        cyc();
        ex_ready = 0;
        cyc();
    endtask

    initial begin
        test_reset();
        test_preload();
        test_raw();
        test_waw();
        test_backpressure();
        test_reset_mid();
        test_nonpending_wb();
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: got %0d entries left want 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/rf_operand_sequencer.md
Name: rf_operand_sequencer

Overview:
Initiator-side controller for the 8-entry general-purpose register file. Accepts decoded instructions (src1, src2, dst) and drives the register file read addresses. Captures the operands and hands them to the execute stage over a valid/ready handshake. Commits execute results back through the register file write port. A per-register pending scoreboard blocks RAW and WAW hazards.

Parameters:
DATA_W, 8, register/operand width
ADDR_W, 3, register address width; NREG = 2**ADDR_W entries

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
req_valid  input  1  instruction request valid
req_ready  output  1  sequencer can accept request
req_src1  input  ADDR_W  operand-1 register
req_src2  input  ADDR_W  operand-2 register
req_dst  input  ADDR_W  destination register
req_wb  input  1  instruction writes req_dst
rf_rd1_add  output  ADDR_W  register file read address 1
rf_rd2_add  output  ADDR_W  register file read address 2
rf_rd1_data  input  DATA_W  register file read data 1 (combinational)
rf_rd2_data  input  DATA_W  register file read data 2 (combinational)
ex_valid  output  1  operands valid to execute
ex_ready  input  1  execute accepts operands
ex_op1  output  DATA_W  captured operand 1
ex_op2  output  DATA_W  captured operand 2
ex_dst  output  ADDR_W  destination tag
ex_wb  output  1  writeback expected
wb_valid  input  1  single-cycle result strobe
wb_dst  input  ADDR_W  result destination
wb_data  input  DATA_W  result data
rf_wr_en  output  1  register file write enable
rf_wr_add  output  ADDR_W  register file write address
rf_wr_data  output  DATA_W  register file write data
pending  output  NREG  scoreboard, bit i = write to Ri outstanding

Behaviour:
- Reset (async, active-low): state S_IDLE; req_ready=1 after release; ex_valid=0; ex_op1/ex_op2/ex_dst/ex_wb=0; rf_wr_en=0, rf_wr_add=0, rf_wr_data=0; pending=0; rf_rd*_add=0. An in-flight instruction is discarded.
- FSM states: S_IDLE, S_FETCH, S_DISPATCH.
- S_IDLE: req_ready=1. On req_valid&req_ready, latch src1/src2/dst/wb and go to S_FETCH. No other transition.
- S_FETCH: req_ready=0. rf_rd1_add/rf_rd2_add are driven from the latched src1/src2. In all other states they hold their last value.
- S_FETCH hazard condition = pending[src1] | pending[src2] | (wb & pending[dst]).
  - Hazard present: stay in S_FETCH (stall).
  - No hazard: on the clock edge capture rf_rd1_data/rf_rd2_data into ex_op1/ex_op2; set ex_dst/ex_wb; if wb, set pending[dst]; go to S_DISPATCH.
- S_DISPATCH: ex_valid=1 and ex_op*/ex_dst/ex_wb stable. On ex_ready, go to S_IDLE with ex_valid=0 next cycle.
- Throughput/latency (no stall): request accepted in cycle 0, S_FETCH in cycle 1, ex_valid high from cycle 2. Minimum 3 cycles per instruction.
- Writeback path runs independently of the FSM:
  - wb_valid in cycle N registers rf_wr_en=1, rf_wr_add=wb_dst, rf_wr_data=wb_data, visible in cycle N+1. rf_wr_en is a one-cycle pulse per strobe.
  - At the end of cycle N+1 the register file commits the write and pending[rf_wr_add] clears on the same edge.
  - A read in cycle N+2 returns the new value.
- wb_valid to a register whose pending bit is clear: the write is still performed and pending is unchanged. This is the preload path.
- Same-edge set and clear of the same pending bit: set wins. Without the optional feature this cannot occur, because the WAW check stalls.
- Back-to-back wb_valid: each strobe produces its own write pulse; no coalescing.
- Width rules: data is passed through unmodified; no arithmetic.

Optional Feature:
Macro RF_SEQ_BYPASS_EN.
- Defined: during S_FETCH, a commit in the same cycle (rf_wr_en=1) is treated as resolved. The pending bit at rf_wr_add is excluded from the hazard check. Any source matching rf_wr_add captures rf_wr_data instead of the register file data. This saves one stall cycle per RAW hazard.
- Undefined: no bypass; the sequencer stalls until the pending bit is cleared.

Test Plan:
- Preload: wb_valid with R2=0x3C, then R5=0xA1; request src1=2, src2=5, dst=7, wb=1 -> ex_valid in cycle 2 with ex_op1=0x3C, ex_op2=0xA1, ex_dst=7; pending=0x80.
- RAW stall: pending[7] set; request src1=7. wb_valid dst=7 data=0x55 in cycle N -> rf_wr_en in N+1, pending=0x00 after N+1, ex_op1=0x55. With RF_SEQ_BYPASS_EN, capture happens in N+1, one cycle earlier.
- WAW: pending[3] set; request dst=3, src1=0, src2=1 -> stays in S_FETCH until R3 commits, then pending[3]=1 again.
- Execute backpressure: ex_ready=0 for 4 cycles -> ex_valid stays 1, operands constant, req_ready=0 throughout; ex_ready=1 -> S_IDLE next cycle.
- Reset mid-operation: assert reset in S_DISPATCH with pending=0x10 -> ex_valid=0, pending=0x00, rf_wr_en=0 immediately (asynchronous); req_ready=1 after release.
- Non-pending writeback: wb_valid dst=4 data=0xFF with pending=0 -> rf_wr_en pulse, rf_wr_add=4, rf_wr_data=0xFF; pending remains 0x00.
